// File: rtl/clock_set_ctrl.sv
// Front-panel time-set controller: synchronises and debounces MODE/INC buttons and runs the
// field-select FSM that emits single-cycle set_hr / set_min / set_AMPM pulses for CLOCK.
module clock_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 8,
    parameter int unsigned REPEAT_RATE     = 2,
    parameter int unsigned IDLE_TIMEOUT    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       set_hr,
    output logic       set_min,
    output logic       set_AMPM,
    output logic [1:0] mode,
    output logic       editing
);

    localparam int unsigned NUM_BTN    = 2;
    localparam int unsigned BTN_MODE   = 0;
    localparam int unsigned BTN_INC    = 1;
    localparam int unsigned DEB_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned REP_MAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned REP_W      = $clog2(REP_MAX + 1);
    localparam int unsigned IDLE_W     = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned ARM_CYCLES = 3;
    localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HR   = 2'd1,
        SET_MIN  = 2'd2,
        SET_AMPM = 2'd3
    } state_t;

    // Button input path
    logic [NUM_BTN-1:0] raw;
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] deb;
    logic [NUM_BTN-1:0] deb_prev;
    logic [NUM_BTN-1:0] armed;
    logic [DEB_W-1:0]   deb_cnt [NUM_BTN];
    logic [ARM_W-1:0]   arm_cnt [NUM_BTN];

    logic mode_rise;
    logic inc_rise;
    logic deb_inc;

    // FSM and timers
    state_t            state;
    state_t            state_nxt;
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_cnt_nxt;
    logic              rep_active;
    logic              rep_active_nxt;
    logic              rep_first;
    logic              rep_first_nxt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_cnt_nxt;
    logic              inc_block;
    logic              inc_block_nxt;
    logic              pulse;
    logic              rep_due;
    logic              set_hr_nxt;
    logic              set_min_nxt;
    logic              set_ampm_nxt;
    logic              editing_nxt;

    assign raw = {btn_inc, btn_mode};

    // Synchroniser, debouncer and arming per button. Arming needs the whole pipeline to read low
    // for ARM_CYCLES edges, so a button held through reset stays inert until released.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            armed    <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                deb_cnt[i] <= '0;
                arm_cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end

                if (!armed[i]) begin
                    if (!sync2[i] && !deb[i]) begin
                        if (arm_cnt[i] == ARM_W'(ARM_CYCLES - 1)) begin
                            armed[i] <= 1'b1;
                        end else begin
                            arm_cnt[i] <= arm_cnt[i] + ARM_W'(1);
                        end
                    end else begin
                        arm_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    assign mode_rise = deb[BTN_MODE] & ~deb_prev[BTN_MODE] & armed[BTN_MODE];
    assign inc_rise  = deb[BTN_INC]  & ~deb_prev[BTN_INC]  & armed[BTN_INC];
    assign deb_inc   = deb[BTN_INC];

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            rep_cnt    <= '0;
            rep_active <= 1'b0;
            rep_first  <= 1'b0;
            idle_cnt   <= '0;
            inc_block  <= 1'b0;
            set_hr     <= 1'b0;
            set_min    <= 1'b0;
            set_AMPM   <= 1'b0;
            editing    <= 1'b0;
        end else begin
            state      <= state_nxt;
            rep_cnt    <= rep_cnt_nxt;
            rep_active <= rep_active_nxt;
            rep_first  <= rep_first_nxt;
            idle_cnt   <= idle_cnt_nxt;
            inc_block  <= inc_block_nxt;
            set_hr     <= set_hr_nxt;
            set_min    <= set_min_nxt;
            set_AMPM   <= set_ampm_nxt;
            editing    <= editing_nxt;
        end
    end

    assign mode = state;

    // Repeat fires after REPEAT_DELAY for the first repeat, REPEAT_RATE thereafter
    assign rep_due = rep_first ? (rep_cnt == REP_W'(REPEAT_DELAY - 1))
                               : (rep_cnt == REP_W'(REPEAT_RATE - 1));

    // Next-state, timers and pulse generation; a MODE press always takes priority over INC
    always_comb begin
        state_nxt      = state;
        rep_cnt_nxt    = rep_cnt;
        rep_active_nxt = rep_active;
        rep_first_nxt  = rep_first;
        idle_cnt_nxt   = idle_cnt;
        inc_block_nxt  = inc_block & deb_inc;
        pulse          = 1'b0;

        if (mode_rise) begin
            case (state)
                RUN:      state_nxt = SET_HR;
                SET_HR:   state_nxt = SET_MIN;
                SET_MIN:  state_nxt = SET_AMPM;
                SET_AMPM: state_nxt = RUN;
                default:  state_nxt = RUN;
            endcase
            rep_cnt_nxt    = '0;
            rep_active_nxt = 1'b0;
            rep_first_nxt  = 1'b0;
            idle_cnt_nxt   = '0;
            inc_block_nxt  = deb_inc;
        end else if (state == RUN) begin
            rep_cnt_nxt    = '0;
            rep_active_nxt = 1'b0;
            rep_first_nxt  = 1'b0;
            idle_cnt_nxt   = '0;
        end else if (inc_rise && !inc_block) begin
            pulse          = 1'b1;
            rep_cnt_nxt    = '0;
            rep_active_nxt = 1'b1;
            rep_first_nxt  = 1'b1;
            idle_cnt_nxt   = '0;
        end else if (deb_inc) begin
            // Held INC pins the idle timer so the user never times out mid-hold
            idle_cnt_nxt = '0;
            if (rep_active) begin
                if (rep_due) begin
                    pulse         = 1'b1;
                    rep_cnt_nxt   = '0;
                    rep_first_nxt = 1'b0;
                end else if (rep_cnt != REP_W'(REP_MAX)) begin
                    rep_cnt_nxt = rep_cnt + REP_W'(1);
                end
            end
        end else begin
            rep_cnt_nxt    = '0;
            rep_active_nxt = 1'b0;
            rep_first_nxt  = 1'b0;
            if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                state_nxt    = RUN;
                idle_cnt_nxt = '0;
            end else begin
                idle_cnt_nxt = idle_cnt + IDLE_W'(1);
            end
        end

        set_hr_nxt   = pulse && (state == SET_HR);
        set_min_nxt  = pulse && (state == SET_MIN);
        set_ampm_nxt = pulse && (state == SET_AMPM);
        editing_nxt  = (state_nxt != RUN);
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl at default parameters.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic       set_hr;
    logic       set_min;
    logic       set_AMPM;
    logic [1:0] mode;
    logic       editing;

    int checks    = 0;
    int failures  = 0;
    int hr_cnt    = 0;
    int min_cnt   = 0;
    int ampm_cnt  = 0;
    int multi_hot = 0;

    always #5 clk = ~clk;

    clock_set_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .set_hr   (set_hr),
        .set_min  (set_min),
        .set_AMPM (set_AMPM),
        .mode     (mode),
        .editing  (editing)
    );

    // Advance one edge, sample just after it and tally pulses
    task automatic tick();
        @(posedge clk);
        #1;
        if (set_hr)   hr_cnt++;
        if (set_min)  min_cnt++;
        if (set_AMPM) ampm_cnt++;
        if ((int'(set_hr) + int'(set_min) + int'(set_AMPM)) > 1) multi_hot++;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        repeat (10) tick();
        btn_mode = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; btn_mode = 1'b1; btn_inc = 1'b0;
        tick();
        btn_mode = 1'b0; btn_inc = 1'b1;
        tick();
        checks++;
        if ({set_hr, set_min, set_AMPM, editing} !== 4'b0000) begin
            failures++; $display("FAIL reset_outputs: got %b expected 0000", {set_hr, set_min, set_AMPM, editing});
        end
        checks++;
        if (mode !== 2'd0) begin failures++; $display("FAIL reset_mode: got %0d expected 0", mode); end

        btn_inc = 1'b0; btn_mode = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        checks++;
        if (mode !== 2'd0 || editing !== 1'b0) begin
            failures++; $display("FAIL held_through_reset: got mode %0d editing %0d expected 0 0", mode, editing);
        end
        btn_mode = 1'b0;
        repeat (12) tick();
        checks++;
        if (mode !== 2'd0) begin failures++; $display("FAIL held_release: got %0d expected 0", mode); end
        btn_mode = 1'b1;
        repeat (7) tick();
        checks++;
        if (mode !== 2'd1) begin failures++; $display("FAIL repress_after_reset: got %0d expected 1", mode); end
        btn_mode = 1'b0;
        repeat (40) tick();
        checks++;
        if (mode !== 2'd0) begin failures++; $display("FAIL first_timeout: got %0d expected 0", mode); end
    endtask

    task automatic test_mode_cycle();
        int base;
        logic [1:0] exp_old;
        logic [1:0] exp_new;
        base = hr_cnt + min_cnt + ampm_cnt;
        for (int i = 0; i < 4; i++) begin
            exp_old = 2'(i);
            exp_new = 2'(i + 1);
            btn_mode = 1'b1;
            repeat (6) tick();
            checks++;
            if (mode !== exp_old) begin failures++; $display("FAIL mode_before_e6[%0d]: got %0d expected %0d", i, mode, exp_old); end
            tick();
            checks++;
            if (mode !== exp_new) begin failures++; $display("FAIL mode_at_e6[%0d]: got %0d expected %0d", i, mode, exp_new); end
            checks++;
            if (editing !== (exp_new != 2'd0)) begin
                failures++; $display("FAIL editing[%0d]: got %0d expected %0d", i, editing, exp_new != 2'd0);
            end
            repeat (3) tick();
            btn_mode = 1'b0;
            repeat (10) tick();
        end
        checks++;
        if (hr_cnt + min_cnt + ampm_cnt !== base) begin
            failures++; $display("FAIL mode_no_pulse: got %0d pulses expected 0", hr_cnt + min_cnt + ampm_cnt - base);
        end
    endtask

    task automatic test_bounce();
        int runs [12] = '{1, 2, 3, 1, 2, 3, 1, 1, 3, 1, 1, 1};
        int base;
        logic lvl;
        btn_mode = 1'b1;
        repeat (7) tick();
        checks++;
        if (mode !== 2'd1) begin failures++; $display("FAIL enter_set_hr: got %0d expected 1", mode); end
        btn_mode = 1'b0;
        base = hr_cnt;
        lvl = 1'b1;
        for (int r = 0; r < 12; r++) begin
            btn_inc = lvl;
            repeat (runs[r]) tick();
            lvl = ~lvl;
        end
        btn_inc = 1'b1;
        repeat (6) tick();
        checks++;
        if (hr_cnt !== base) begin failures++; $display("FAIL bounce_accepted: got %0d pulses expected 0", hr_cnt - base); end
        tick();
        checks++;
        if (set_hr !== 1'b1) begin failures++; $display("FAIL bounce_pulse_at_s6: got %0d expected 1", set_hr); end
        btn_inc = 1'b0;
        tick();
        checks++;
        if (set_hr !== 1'b0) begin failures++; $display("FAIL pulse_width: got %0d expected 0", set_hr); end
        repeat (20) tick();
        checks++;
        if (hr_cnt !== base + 1) begin failures++; $display("FAIL bounce_total: got %0d expected 1", hr_cnt - base); end
    endtask

    task automatic test_repeat();
        int  base;
        logic exp;
        btn_mode = 1'b1;
        repeat (7) tick();
        checks++;
        if (mode !== 2'd2) begin failures++; $display("FAIL enter_set_min: got %0d expected 2", mode); end
        btn_mode = 1'b0;
        btn_inc = 1'b1;
        base = min_cnt;
        repeat (6) tick();
        checks++;
        if (min_cnt !== base) begin failures++; $display("FAIL repeat_early: got %0d pulses expected 0", min_cnt - base); end
        for (int k = 0; k <= 40; k++) begin
            tick();
            exp = (k == 0) || (k == 8) || (k >= 10 && k <= 28 && (k % 2) == 0);
            checks++;
            if (set_min !== exp) begin failures++; $display("FAIL repeat_p%0d: got %0d expected %0d", k, set_min, exp); end
            if (k == 23) btn_inc = 1'b0;
        end
        checks++;
        if (min_cnt !== base + 12) begin failures++; $display("FAIL repeat_total: got %0d expected 12", min_cnt - base); end
    endtask

    task automatic test_timeout();
        int base;
        repeat (40) tick();
        checks++;
        if (mode !== 2'd0) begin failures++; $display("FAIL set_min_timeout: got %0d expected 0", mode); end
        btn_mode = 1'b1;
        repeat (7) tick();
        btn_mode = 1'b0;
        checks++;
        if (mode !== 2'd1) begin failures++; $display("FAIL timeout_enter: got %0d expected 1", mode); end
        repeat (31) tick();
        checks++;
        if (mode !== 2'd1) begin failures++; $display("FAIL timeout_early: got %0d expected 1", mode); end
        tick();
        checks++;
        if (mode !== 2'd0) begin failures++; $display("FAIL timeout_at_32: got %0d expected 0", mode); end

        press_mode();
        press_mode();
        press_mode();
        checks++;
        if (mode !== 2'd3) begin failures++; $display("FAIL enter_set_ampm: got %0d expected 3", mode); end
        base = ampm_cnt;
        btn_inc = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            checks++;
            if (mode !== 2'd3) begin failures++; $display("FAIL held_inc_timeout_c%0d: got %0d expected 3", k, mode); end
        end
        checks++;
        if (ampm_cnt !== base + 44) begin failures++; $display("FAIL ampm_repeat_count: got %0d expected 44", ampm_cnt - base); end
        btn_inc = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_simultaneous();
        int base_hr;
        int base_min;
        press_mode();
        press_mode();
        checks++;
        if (mode !== 2'd1) begin failures++; $display("FAIL simul_enter: got %0d expected 1", mode); end
        base_hr = hr_cnt;
        base_min = min_cnt;
        btn_mode = 1'b1;
        btn_inc = 1'b1;
        repeat (6) tick();
        checks++;
        if (mode !== 2'd1) begin failures++; $display("FAIL simul_before: got %0d expected 1", mode); end
        tick();
        checks++;
        if (mode !== 2'd2) begin failures++; $display("FAIL simul_mode_wins: got %0d expected 2", mode); end
        checks++;
        if (set_hr !== 1'b0 || set_min !== 1'b0) begin
            failures++; $display("FAIL simul_pulse: got hr %0d min %0d expected 0 0", set_hr, set_min);
        end
        repeat (20) tick();
        checks++;
        if (hr_cnt !== base_hr || min_cnt !== base_min || mode !== 2'd2) begin
            failures++; $display("FAIL simul_held_ignored: got hr %0d min %0d mode %0d expected 0 0 2",
                                 hr_cnt - base_hr, min_cnt - base_min, mode);
        end
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        repeat (10) tick();
        checks++;
        if (hr_cnt !== base_hr || min_cnt !== base_min) begin
            failures++; $display("FAIL simul_release: got hr %0d min %0d expected 0 0", hr_cnt - base_hr, min_cnt - base_min);
        end
    endtask

    task automatic test_reset_in_repeat();
        int base;
        base = min_cnt;
        btn_inc = 1'b1;
        repeat (7) tick();
        checks++;
        if (set_min !== 1'b1) begin failures++; $display("FAIL rr_first_pulse: got %0d expected 1", set_min); end
        repeat (9) tick();
        checks++;
        if (min_cnt !== base + 2) begin failures++; $display("FAIL rr_before_reset: got %0d expected 2", min_cnt - base); end
        rst = 1'b1;
        tick();
        checks++;
        if ({set_hr, set_min, set_AMPM, editing} !== 4'b0000 || mode !== 2'd0) begin
            failures++; $display("FAIL rr_reset_cycle: got %b mode %0d expected 0000 mode 0",
                                 {set_hr, set_min, set_AMPM, editing}, mode);
        end
        tick();
        rst = 1'b0;
        repeat (30) tick();
        checks++;
        if (min_cnt !== base + 2 || mode !== 2'd0) begin
            failures++; $display("FAIL rr_after_reset: got %0d pulses mode %0d expected 2 mode 0", min_cnt - base, mode);
        end
        btn_inc = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        rst = 1'b1;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        test_reset();
        test_mode_cycle();
        test_bounce();
        test_repeat();
        test_timeout();
        test_simultaneous();
        test_reset_in_repeat();
        checks++;
        if (multi_hot !== 0) begin failures++; $display("FAIL exclusivity: got %0d multi-hot cycles expected 0", multi_hot); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
